cnn_layer_accel_rd_arb: RTL
===========================

// Module: cnn_layer_accel_rd_arb
// PURPOSE
//  Round-robin arbiter sharing the single memory read initiator port among C_NUM_CLIENTS cnn_layer_accel read clients.
//  Clients are the AWP/QUAD/FAS fetchers; the memory side is the shell read port.
//  Grants one request at a time and forwards it downstream, then routes the returned data stream and completion back to the granted client.
//  Exactly one transaction is outstanding at any time.
// PARAMETERS
//  C_NUM_CLIENTS   4     number of read clients (>=2)
//  C_ID_WTH        8     request id width (`INIT_ID_WTH)
//  C_ADDR_WTH      64    address width (`INIT_ADDR_WTH)
//  C_LEN_WTH       32    length width, units = data beats (`INIT_LEN_WTH)
//  C_DATA_WTH      512   data beat width (`INIT_DATA_WTH)
// PORTS
//  clk_intf         in   1                     clock; single clock domain
//  rst              in   1                     synchronous, active-high reset
//  cl_rd_req        in   N                     per-client request, level; held until cl_rd_req_ack
//  cl_rd_req_id     in   N*C_ID_WTH            packed ids; client i uses [i*W +: W]
//  cl_rd_addr       in   N*C_ADDR_WTH          packed addresses
//  cl_rd_len        in   N*C_LEN_WTH           packed beat counts
//  cl_rd_req_ack    out  N                     one-cycle accept pulse to the granted client
//  cl_rd_data       out  C_DATA_WTH            broadcast data (mem_rd_data passthrough)
//  cl_rd_data_vld   out  N                     data valid, granted client only
//  cl_rd_data_rdy   in   N                     per-client ready
//  cl_rd_cmpl       out  N                     one-cycle completion pulse
//  mem_rd_req       out  1                     downstream request, held until ack
//  mem_rd_req_id    out  C_ID_WTH              latched id of the granted client
//  mem_rd_addr      out  C_ADDR_WTH            latched address
//  mem_rd_len       out  C_LEN_WTH             latched length
//  mem_rd_req_ack   in   1                     downstream accept
//  mem_rd_data      in   C_DATA_WTH            returned beat
//  mem_rd_data_vld  in   1                     beat valid
//  mem_rd_data_rdy  out  1                     = cl_rd_data_rdy[grant] in DATA state, else 0
//  mem_rd_cmpl      in   1                     transaction complete pulse
//  arb_busy         out  1                     high whenever state != IDLE
//  arb_len_err      out  1                     sticky: beat count != latched len when mem_rd_cmpl arrives
// BEHAVIOUR
//  Reset:
//   - state=IDLE, rr_ptr=N-1 (client 0 has first priority), beat_cnt=0.
//   - All outputs 0; the latched id/addr/len registers also clear to 0.
//  FSM:
//   - IDLE -> ISSUE when |cl_rd_req.
//   - ISSUE -> DATA on mem_rd_req_ack.
//   - DATA -> IDLE on mem_rd_cmpl.
//  IDLE:
//   - Winner = first requesting index scanning rr_ptr+1 upward, with wrap.
//   - Latch grant, id, addr and len in the same cycle.
//  ISSUE:
//   - mem_rd_req=1 starting the cycle after the grant (1-cycle latency req->mem_rd_req).
//   - mem_rd_req and its fields are stable until ack.
//   - In the ack cycle: cl_rd_req_ack[grant] pulses (registered, visible the next cycle) and mem_rd_req drops.
//  DATA:
//   - cl_rd_data_vld[grant] = mem_rd_data_vld (combinational, 0 latency).
//   - mem_rd_data_rdy = cl_rd_data_rdy[grant].
//   - beat_cnt increments on each vld&&rdy.
//  Completion:
//   - On mem_rd_cmpl: cl_rd_cmpl[grant] pulses 1 cycle (registered), rr_ptr<=grant, beat_cnt<=0.
//   - Same cycle: arb_len_err |= (beat_cnt + (vld&&rdy)) != len.
//  Back-to-back: IDLE re-arbitrates on the cycle after cmpl; the minimum gap between grants is 1 IDLE cycle.
//  Protocol rules:
//   - Requests arriving during ISSUE/DATA wait; nothing is lost because req is level-held.
//   - A client withdrawing req after being latched is a protocol violation; the latched request still issues.
//   - Non-granted clients see cl_rd_data_vld=0; data is never duplicated.
//   - mem_rd_data_vld or mem_rd_cmpl outside DATA is ignored.
//   - mem_rd_req_ack outside ISSUE is ignored.
//   - len=0 is forwarded unchanged; cmpl with 0 beats is legal.
//  rst mid-transaction: immediate return to IDLE with all outputs 0; the downstream is reset by the same rst.
//  arb_len_err clears only on rst.
// STRUCTURE
//  Package cnn_layer_accel_rd_arb_pkg:
//   - rd_arb_state_t enum {IDLE, ISSUE, DATA}.
//   - Function rr_pick(req, ptr) returning {found, idx}.
//  Sub-module cnn_layer_accel_rr_pick: combinational round-robin picker (req[N], ptr) -> one-hot + index; reusable for the write arbiter.
// TESTING
//  1 Single client 2, len=4, ack after 3 cycles, 4 beats -> mem_rd_addr/id = client-2 values; cl_rd_req_ack[2] once; 4 vld beats to client 2 only; cl_rd_cmpl[2] once; arb_len_err=0.
//  2 All 4 requesting continuously after reset -> grant order 0,1,2,3,0; no client starved.
//  3 Client rdy toggled 1-0-1 during DATA -> mem_rd_data_rdy mirrors it; beat_cnt counts only vld&&rdy; no beat dropped or duplicated.
//  4 len=8, cmpl after 7 beats -> arb_len_err=1 and stays 1 through later good transactions until rst.
//  5 rst asserted in DATA after 2 of 4 beats -> next cycle all outputs 0, state IDLE; the next grant goes to client 0.
//  6 Stray mem_rd_cmpl/mem_rd_data_vld in IDLE -> no cl_* pulse; state unchanged.

Source files
------------

// File: rtl/cnn_layer_accel_rd_arb_pkg.sv
// Shared types and the round-robin pick helper for the cnn_layer_accel read/write arbiters.
package cnn_layer_accel_rd_arb_pkg;

   localparam int unsigned C_MAX_CLIENTS = 32;
   localparam int unsigned C_IDX_WTH     = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } rd_arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [C_IDX_WTH-1:0] idx;
   } rr_pick_t;

   // First set bit of req scanning upward from ptr+1, wrapping modulo n.
   function automatic rr_pick_t rr_pick(input logic [C_MAX_CLIENTS-1:0] req,
                                        input logic [C_IDX_WTH-1:0]     ptr,
                                        input int unsigned              n);
      rr_pick_t    res;
      int unsigned cand;
      res = '0;
      for (int unsigned k = 1; k <= C_MAX_CLIENTS; k++) begin
         if (k <= n) begin
            cand = (32'(ptr) + k) % n;
            if (!res.found && req[cand[C_IDX_WTH-1:0]]) begin
               res.found = 1'b1;
               res.idx   = cand[C_IDX_WTH-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_pick.sv
// Combinational round-robin picker: request vector plus last-winner pointer -> winner index and one-hot.
module cnn_layer_accel_rr_pick
   import cnn_layer_accel_rd_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o,
   output logic [N-1:0]     onehot_o
);

   logic [C_MAX_CLIENTS-1:0] req_ext;
   rr_pick_t                 pick;
   logic                     unused_pick_idx;

   // Widen the request vector to the helper's fixed width and pick the winner.
   always_comb begin
      req_ext          = '0;
      req_ext[N-1:0]   = req_i;
      pick             = rr_pick(req_ext, C_IDX_WTH'(ptr_i), N);
   end

   assign found_o         = pick.found;
   assign idx_o           = pick.idx[IDX_W-1:0];
   assign onehot_o        = pick.found ? (N'(1) << pick.idx[IDX_W-1:0]) : '0;
   assign unused_pick_idx = ^pick.idx;

endmodule

// File: rtl/cnn_layer_accel_rd_arb.sv
// Round-robin arbiter sharing one memory read port among the cnn_layer_accel read clients.
// One transaction outstanding at a time: grant, issue downstream, stream data back, complete.
module cnn_layer_accel_rd_arb
   import cnn_layer_accel_rd_arb_pkg::*;
#(
   parameter int C_NUM_CLIENTS = 4,
   parameter int C_ID_WTH      = 8,
   parameter int C_ADDR_WTH    = 64,
   parameter int C_LEN_WTH     = 32,
   parameter int C_DATA_WTH    = 512
) (
   input  logic                                 clk_intf,
   input  logic                                 rst,
   input  logic [C_NUM_CLIENTS-1:0]             cl_rd_req,
   input  logic [C_NUM_CLIENTS*C_ID_WTH-1:0]    cl_rd_req_id,
   input  logic [C_NUM_CLIENTS*C_ADDR_WTH-1:0]  cl_rd_addr,
   input  logic [C_NUM_CLIENTS*C_LEN_WTH-1:0]   cl_rd_len,
   output logic [C_NUM_CLIENTS-1:0]             cl_rd_req_ack,
   output logic [C_DATA_WTH-1:0]                cl_rd_data,
   output logic [C_NUM_CLIENTS-1:0]             cl_rd_data_vld,
   input  logic [C_NUM_CLIENTS-1:0]             cl_rd_data_rdy,
   output logic [C_NUM_CLIENTS-1:0]             cl_rd_cmpl,
   output logic                                 mem_rd_req,
   output logic [C_ID_WTH-1:0]                  mem_rd_req_id,
   output logic [C_ADDR_WTH-1:0]                mem_rd_addr,
   output logic [C_LEN_WTH-1:0]                 mem_rd_len,
   input  logic                                 mem_rd_req_ack,
   input  logic [C_DATA_WTH-1:0]                mem_rd_data,
   input  logic                                 mem_rd_data_vld,
   output logic                                 mem_rd_data_rdy,
   input  logic                                 mem_rd_cmpl,
   output logic                                 arb_busy,
   output logic                                 arb_len_err
);

   localparam int C_GNT_WTH = (C_NUM_CLIENTS > 1) ? $clog2(C_NUM_CLIENTS) : 1;

   rd_arb_state_t             state_q, state_d;
   logic [C_GNT_WTH-1:0]      rr_ptr_q, rr_ptr_d;
   logic [C_GNT_WTH-1:0]      gnt_idx_q, gnt_idx_d;
   logic [C_NUM_CLIENTS-1:0]  gnt_oh_q, gnt_oh_d;
   logic [C_ID_WTH-1:0]       id_q, id_d;
   logic [C_ADDR_WTH-1:0]     addr_q, addr_d;
   logic [C_LEN_WTH-1:0]      len_q, len_d;
   logic [C_LEN_WTH-1:0]      beat_cnt_q, beat_cnt_d;
   logic [C_NUM_CLIENTS-1:0]  req_ack_q, req_ack_d;
   logic [C_NUM_CLIENTS-1:0]  cmpl_q, cmpl_d;
   logic                      len_err_q, len_err_d;

   logic                      pick_found;
   logic [C_GNT_WTH-1:0]      pick_idx;
   logic [C_NUM_CLIENTS-1:0]  pick_oh;
   logic                      beat_fire;
   logic [C_LEN_WTH-1:0]      beat_nxt;

   cnn_layer_accel_rr_pick #(
      .N     (C_NUM_CLIENTS),
      .IDX_W (C_GNT_WTH)
   ) u_rr_pick (
      .req_i    (cl_rd_req),
      .ptr_i    (rr_ptr_q),
      .found_o  (pick_found),
      .idx_o    (pick_idx),
      .onehot_o (pick_oh)
   );

   // A beat moves only in DATA when the memory offers it and the granted client takes it.
   assign beat_fire       = (state_q == DATA) && mem_rd_data_vld && cl_rd_data_rdy[gnt_idx_q];
   assign beat_nxt        = beat_cnt_q + C_LEN_WTH'(beat_fire);

   assign cl_rd_data      = mem_rd_data;
   assign cl_rd_data_vld  = ((state_q == DATA) && mem_rd_data_vld) ? gnt_oh_q : '0;
   assign mem_rd_data_rdy = (state_q == DATA) && cl_rd_data_rdy[gnt_idx_q];
   assign mem_rd_req      = (state_q == ISSUE);
   assign mem_rd_req_id   = id_q;
   assign mem_rd_addr     = addr_q;
   assign mem_rd_len      = len_q;
   assign cl_rd_req_ack   = req_ack_q;
   assign cl_rd_cmpl      = cmpl_q;
   assign arb_busy        = (state_q != IDLE);
   assign arb_len_err     = len_err_q;

   // Next-state and latch logic; ack/cmpl pulses default low every cycle.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_oh_d   = gnt_oh_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      req_ack_d  = '0;
      cmpl_d     = '0;
      len_err_d  = len_err_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d   = ISSUE;
               gnt_idx_d = pick_idx;
               gnt_oh_d  = pick_oh;
               id_d      = cl_rd_req_id[32'(pick_idx) * C_ID_WTH +: C_ID_WTH];
               addr_d    = cl_rd_addr[32'(pick_idx) * C_ADDR_WTH +: C_ADDR_WTH];
               len_d     = cl_rd_len[32'(pick_idx) * C_LEN_WTH +: C_LEN_WTH];
            end
         end
         ISSUE: begin
            if (mem_rd_req_ack) begin
               state_d   = DATA;
               req_ack_d = gnt_oh_q;
            end
         end
         DATA: begin
            if (beat_fire) begin
               beat_cnt_d = beat_nxt;
            end
            if (mem_rd_cmpl) begin
               state_d    = IDLE;
               cmpl_d     = gnt_oh_q;
               rr_ptr_d   = gnt_idx_q;
               beat_cnt_d = '0;
               len_err_d  = len_err_q | (beat_nxt != len_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-request registers with synchronous reset.
   always_ff @(posedge clk_intf) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= C_GNT_WTH'(C_NUM_CLIENTS - 1);
         gnt_idx_q  <= '0;
         gnt_oh_q   <= '0;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         req_ack_q  <= '0;
         cmpl_q     <= '0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_oh_q   <= gnt_oh_d;
         id_q       <= id_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         req_ack_q  <= req_ack_d;
         cmpl_q     <= cmpl_d;
         len_err_q  <= len_err_d;
      end
   end

endmodule
